mem_arbiter: RTL and testbench

- Arbitrates one single-ported unified instruction/data RAM between the fetch stage and the memory stage of the 5-stage pipeline.
- Sequences each RAM transaction through an ack handshake.
- Generates the stall signals that freeze PC / IF_ID and the downstream pipeline registers.
- Supports fetch squash on a taken branch, and aborts on ack timeout.

---
 rtl/mem_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported unified I/D RAM between fetch and memory stages.
// Optional stall-cycle counters are enabled by defining ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_word,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_word,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              err
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stall_cnt_if,
  output logic [31:0]       stall_cnt_mem
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                squash_q, squash_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_word_q, ram_word_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                err_q, err_d;

  logic                mem_go;
  logic                if_go;
  logic                expired;

  // A requester still shows its just-completed request in its ready cycle; don't reissue it.
  assign mem_go  = mem_req & ~mem_ready_q;
  assign if_go   = if_req & ~if_ready_q;
  assign expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    squash_d    = squash_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_word_d  = ram_word_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if (mem_go) begin
          state_d     = DATA;
          cnt_d       = '0;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_word_d  = mem_word;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
        end else if (if_go) begin
          state_d    = INST;
          cnt_d      = '0;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_word_d = 1'b1;
          ram_addr_d = if_addr;
          squash_d   = if_flush;
        end
      end

      DATA: begin
        if (ram_ack) begin
          state_d     = IDLE;
          ram_en_d    = 1'b0;
          mem_ready_d = 1'b1;
          if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end
        end else if (expired) begin
          state_d  = IDLE;
          ram_en_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      INST: begin
        // A flush in the ack cycle itself still squashes the delivery.
        if (ram_ack) begin
          state_d  = IDLE;
          ram_en_d = 1'b0;
          squash_d = 1'b0;
          if (!(squash_q | if_flush)) begin
            if_ready_d = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end else if (expired) begin
          state_d  = IDLE;
          ram_en_d = 1'b0;
          squash_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          squash_d = squash_q | if_flush;
        end
      end

      default: begin
        state_d  = IDLE;
        ram_en_d = 1'b0;
        squash_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      squash_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_word_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      squash_q    <= squash_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_word_q  <= ram_word_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_word    = ram_word_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign if_ready    = if_ready_q;
  assign if_rdata    = if_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign err         = err_q;

  // Stalls are combinational so the pipeline releases in the ready cycle itself.
  assign stall_mem   = mem_req & ~mem_ready_q;
  assign stall_fetch = (if_req & ~if_ready_q) | stall_mem;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt_if_q, stall_cnt_if_d;
  logic [STAT_W-1:0] stall_cnt_mem_q, stall_cnt_mem_d;

  // Saturating stall-cycle counters
  always_comb begin
    stall_cnt_if_d  = stall_cnt_if_q;
    stall_cnt_mem_d = stall_cnt_mem_q;
    if (stall_fetch && !stall_mem && (stall_cnt_if_q != '1)) begin
      stall_cnt_if_d = stall_cnt_if_q + STAT_W'(1);
    end
    if (stall_mem && (stall_cnt_mem_q != '1)) begin
      stall_cnt_mem_d = stall_cnt_mem_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      stall_cnt_if_q  <= '0;
      stall_cnt_mem_q <= '0;
    end else begin
      stall_cnt_if_q  <= stall_cnt_if_d;
      stall_cnt_mem_q <= stall_cnt_mem_d;
    end
  end

  assign stall_cnt_if  = stall_cnt_if_q;
  assign stall_cnt_mem = stall_cnt_mem_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus a timeout/reset sequence.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;

  logic          clock = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_ready;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          mem_req, mem_we, mem_word, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          ram_en, ram_we, ram_word, ram_ack;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          stall_fetch, stall_mem, err;
`ifdef ARB_STATS_EN
  logic [31:0]   stall_cnt_if, stall_cnt_mem;
`endif

  always #5 clock = ~clock;

  mem_arbiter #(.ACK_TIMEOUT(4), .ADDR_W(AW)) dut (
    .clock(clock), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_word(mem_word),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_word(ram_word),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem), .err(err)
`ifdef ARB_STATS_EN
    , .stall_cnt_if(stall_cnt_if), .stall_cnt_mem(stall_cnt_mem)
`endif
  );

  typedef struct packed {
    logic        en;
    logic        rwe;
    logic        rword;
    logic [31:0] raddr;
    logic [31:0] rwd;
    logic        ifrdy;
    logic [31:0] ifd;
    logic        mrdy;
    logic [31:0] md;
    logic        sf;
    logic        sm;
    logic        er;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ia;
    logic        fl;
    logic        mr;
    logic        we;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    exp_t        exp;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic vec(input logic r, input logic ifr, input logic [31:0] ia, input logic fl,
                     input logic mr, input logic we, input logic mw, input logic [31:0] ma,
                     input logic [31:0] wd, input logic ack, input logic [31:0] rd,
                     input logic en, input logic rwe, input logic rword, input logic [31:0] raddr,
                     input logic [31:0] rwd, input logic ifrdy, input logic [31:0] ifd,
                     input logic mrdy, input logic [31:0] md, input logic sf, input logic sm,
                     input logic er);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ia = ia; v.fl = fl; v.mr = mr; v.we = we; v.mw = mw;
    v.ma = ma; v.wd = wd; v.ack = ack; v.rd = rd;
    v.exp = '{en: en, rwe: rwe, rword: rword, raddr: raddr, rwd: rwd, ifrdy: ifrdy,
              ifd: ifd, mrdy: mrdy, md: md, sf: sf, sm: sm, er: er};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_word = 1'b0; mem_addr = '0; mem_wdata = '0;
    ram_ack = 1'b0; ram_rdata = '0;
  endtask

  initial begin
    exp_t act;
    int   en_cyc;
    bit   seen_rdy;
    bit   done;

    // Columns: rst ifr ia fl mr we mw ma wd ack rd | en rwe rword raddr rwd ifrdy ifd mrdy md sf sm err
    // Basic fetch, ack in the second RAM cycle
    vec(0,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0,0);
    vec(1,1,32'h10,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,1,0,0);
    vec(1,1,32'h10,0, 0,0,0,32'h0,32'h0, 0,32'h0,         1,0,1,32'h10,32'h0,0,32'h0,0,32'h0,1,0,0);
    vec(1,1,32'h10,0, 0,0,0,32'h0,32'h0, 1,32'h8C010004,  1,0,1,32'h10,32'h0,0,32'h0,0,32'h0,1,0,0);
    vec(1,1,32'h10,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h10,32'h0,1,32'h8C010004,0,32'h0,0,0,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'h10,32'h0,0,32'h8C010004,0,32'h0,0,0,0);
    // Simultaneous load and fetch: data first, fetch granted in the mem_ready cycle
    vec(1,1,32'h14,0, 1,0,1,32'h40,32'h0, 0,32'h0,        0,0,1,32'h10,32'h0,0,32'h8C010004,0,32'h0,1,1,0);
    vec(1,1,32'h14,0, 1,0,1,32'h40,32'h0, 1,32'h11112222, 1,0,1,32'h40,32'h0,0,32'h8C010004,0,32'h0,1,1,0);
    vec(1,1,32'h14,0, 1,0,1,32'h40,32'h0, 0,32'h0,        0,0,1,32'h40,32'h0,0,32'h8C010004,1,32'h11112222,1,0,0);
    vec(1,1,32'h14,0, 0,0,0,32'h0,32'h0, 1,32'hAAAA0001,  1,0,1,32'h14,32'h0,0,32'h8C010004,0,32'h11112222,1,0,0);
    vec(1,1,32'h14,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h14,32'h0,1,32'hAAAA0001,0,32'h11112222,0,0,0);
    // Byte store held three cycles
    vec(1,0,32'h0,0, 1,1,0,32'h80,32'hDEADBEEF, 0,32'h0,  0,0,1,32'h14,32'h0,0,32'hAAAA0001,0,32'h11112222,1,1,0);
    vec(1,0,32'h0,0, 1,1,0,32'h80,32'hDEADBEEF, 0,32'h0,  1,1,0,32'h80,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,1,0);
    vec(1,0,32'h0,0, 1,1,0,32'h80,32'hDEADBEEF, 0,32'h0,  1,1,0,32'h80,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,1,0);
    vec(1,0,32'h0,0, 1,1,0,32'h80,32'hDEADBEEF, 1,32'h55555555, 1,1,0,32'h80,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,1,0);
    vec(1,0,32'h0,0, 1,1,0,32'h80,32'hDEADBEEF, 0,32'h0,  0,1,0,32'h80,32'hDEADBEEF,0,32'hAAAA0001,1,32'h11112222,0,0,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,1,0,32'h80,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,0,0,0);
    // Fetch flushed mid-flight, then a normal fetch to the new target
    vec(1,1,32'h20,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,1,0,32'h80,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,0,0);
    vec(1,1,32'h20,1, 0,0,0,32'h0,32'h0, 0,32'h0,         1,0,1,32'h20,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,0,0);
    vec(1,1,32'h20,0, 0,0,0,32'h0,32'h0, 0,32'h0,         1,0,1,32'h20,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,0,0);
    vec(1,1,32'h20,0, 0,0,0,32'h0,32'h0, 1,32'hBADBAD00,  1,0,1,32'h20,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,0,0);
    vec(1,1,32'h44,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h20,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,0,0);
    vec(1,1,32'h44,0, 0,0,0,32'h0,32'h0, 1,32'h01234567,  1,0,1,32'h44,32'hDEADBEEF,0,32'hAAAA0001,0,32'h11112222,1,0,0);
    vec(1,1,32'h44,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h44,32'hDEADBEEF,1,32'h01234567,0,32'h11112222,0,0,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'h44,32'hDEADBEEF,0,32'h01234567,0,32'h11112222,0,0,0);
    // Load timeout after four unacknowledged cycles; err sticky until reset
    vec(1,0,32'h0,0, 1,0,1,32'hC0,32'h0, 0,32'h0,         0,0,1,32'h44,32'hDEADBEEF,0,32'h01234567,0,32'h11112222,1,1,0);
    for (int i = 0; i < 4; i++)
      vec(1,0,32'h0,0, 1,0,1,32'hC0,32'h0, 0,32'h0,       1,0,1,32'hC0,32'h0,0,32'h01234567,0,32'h11112222,1,1,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'hC0,32'h0,0,32'h01234567,0,32'h11112222,0,0,1);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'hC0,32'h0,0,32'h01234567,0,32'h11112222,0,0,1);
    vec(0,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'hC0,32'h0,0,32'h01234567,0,32'h11112222,0,0,1);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0,0);
    // Reset during DATA; the late ack is ignored
    vec(1,0,32'h0,0, 1,0,1,32'h60,32'h0, 0,32'h0,         0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,1,1,0);
    vec(0,0,32'h0,0, 1,0,1,32'h60,32'h0, 0,32'h0,         1,0,1,32'h60,32'h0,0,32'h0,0,32'h0,1,1,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 1,32'hFFFF0000,   0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,0,0,0);
    // Ack in the same cycle the timeout would expire: normal completion
    vec(1,0,32'h0,0, 1,0,1,32'h70,32'h0, 0,32'h0,         0,0,0,32'h0,32'h0,0,32'h0,0,32'h0,1,1,0);
    for (int i = 0; i < 3; i++)
      vec(1,0,32'h0,0, 1,0,1,32'h70,32'h0, 0,32'h0,       1,0,1,32'h70,32'h0,0,32'h0,0,32'h0,1,1,0);
    vec(1,0,32'h0,0, 1,0,1,32'h70,32'h0, 1,32'hCAFE0001,  1,0,1,32'h70,32'h0,0,32'h0,0,32'h0,1,1,0);
    vec(1,0,32'h0,0, 1,0,1,32'h70,32'h0, 0,32'h0,         0,0,1,32'h70,32'h0,0,32'h0,1,32'hCAFE0001,0,0,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'h70,32'h0,0,32'h0,0,32'hCAFE0001,0,0,0);
    // Flush in the grant cycle squashes that fetch; the refetch is delivered
    vec(1,1,32'h80,1, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h70,32'h0,0,32'h0,0,32'hCAFE0001,1,0,0);
    vec(1,1,32'h80,0, 0,0,0,32'h0,32'h0, 1,32'h12121212,  1,0,1,32'h80,32'h0,0,32'h0,0,32'hCAFE0001,1,0,0);
    vec(1,1,32'h84,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h80,32'h0,0,32'h0,0,32'hCAFE0001,1,0,0);
    vec(1,1,32'h84,0, 0,0,0,32'h0,32'h0, 1,32'h34343434,  1,0,1,32'h84,32'h0,0,32'h0,0,32'hCAFE0001,1,0,0);
    vec(1,1,32'h84,0, 0,0,0,32'h0,32'h0, 0,32'h0,         0,0,1,32'h84,32'h0,1,32'h34343434,0,32'hCAFE0001,0,0,0);
    vec(1,0,32'h0,0, 0,0,0,32'h0,32'h0, 0,32'h0,          0,0,1,32'h84,32'h0,0,32'h34343434,0,32'hCAFE0001,0,0,0);

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);

    foreach (vq[i]) begin
      @(negedge clock);
      rst = vq[i].rst; if_req = vq[i].ifr; if_addr = vq[i].ia; if_flush = vq[i].fl;
      mem_req = vq[i].mr; mem_we = vq[i].we; mem_word = vq[i].mw; mem_addr = vq[i].ma;
      mem_wdata = vq[i].wd; ram_ack = vq[i].ack; ram_rdata = vq[i].rd;
      #1;
      act = {ram_en, ram_we, ram_word, ram_addr, ram_wdata, if_ready, if_rdata,
             mem_ready, mem_rdata, stall_fetch, stall_mem, err};
      total++;
      if (act !== vq[i].exp) begin
        bad++;
        $display("FAIL row %0d: got %h want %h", i, act, vq[i].exp);
      end
    end

    // Unacknowledged fetch: bounded wait for ram_en to drop
    if_req = 1'b1; if_addr = 32'h90;
    en_cyc = 0; seen_rdy = 1'b0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock); #1;
      if (if_ready) seen_rdy = 1'b1;
      if (ram_en) en_cyc++;
      else if (en_cyc > 0) done = 1'b1;
    end
    chk("fetch_timeout_reached", 32'(done), 32'd1);
    chk("fetch_timeout_en_cycles", 32'(en_cyc), 32'd4);
    chk("fetch_timeout_no_ready", 32'(seen_rdy), 32'd0);
    chk("fetch_timeout_err", 32'(err), 32'd1);
    chk("fetch_timeout_stall", 32'(stall_fetch), 32'd1);
    if_req = 1'b0;
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_reset", 32'(err), 32'd0);
    chk("ram_en_after_reset", 32'(ram_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
